// File: rtl/dm_pkg.sv
// Shared types and helpers for the dm_param data memory: access-size
// encodings, controller FSM states and the load-extension function.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // raw holds the addressed byte in [7:0] (and the next one in [15:8] for halves).
    function automatic logic [31:0] ext_load(input size_e size, input logic is_unsigned,
                                             input logic [31:0] raw);
        logic [31:0] result;
        result = '0;
        case (size)
            SZ_B:    result = is_unsigned ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_H:    result = is_unsigned ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            SZ_W:    result = raw;
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Byte-lane select and sign/zero extension of an aligned 32-bit memory word.
// Purely combinational so the forwarding logic can reuse it.
module dm_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {off, 3'b000};
    assign data    = ext_load(size_e'(size), is_unsigned, shifted);

endmodule

// File: rtl/dm_param.sv
// Parametrised byte-addressed little-endian data memory with valid/ready requests,
// RD_LAT-cycle loads and a one-cycle response strobe. DM_ALIGN_CHECK_EN rejects misaligned accesses.
module dm_param
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    // NOTE: the array is zeroed once at time zero and never by rst; a reset loop over
    // every entry would turn the storage into flops instead of RAM.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    state_e            state, next_state;
    logic [1:0]        cnt;
    logic              accept;
    logic [ADDR_W-1:0] eff_addr;
    logic              req_err;
    logic [ADDR_W-3:0] word_hi;
    logic [1:0]        off;
    logic [31:0]       mem_word;
    logic [3:0]        be;
    logic [31:0]       lane;
    logic              wr_en;

    logic [31:0] hold_word;
    logic [1:0]  hold_off;
    logic [1:0]  hold_size;
    logic        hold_uns;
    logic        hold_we;
    logic        hold_err;

    logic [31:0] src_word;
    logic [1:0]  src_off;
    logic [1:0]  src_size;
    logic        src_uns;
    logic        src_we;
    logic        src_err;
    logic [31:0] ext_data;

    logic        valid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    assign req_ready = !rst && (state != S_WAIT);
    assign accept    = req_valid && req_ready;

`ifdef DM_ALIGN_CHECK_EN
    assign eff_addr = req_addr;
    assign req_err  = (req_size == SZ_RSV)
                   || (req_size == SZ_H && req_addr[0])
                   || (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        eff_addr = req_addr;
        if (req_size == SZ_H)
            eff_addr[0] = 1'b0;
        else if (req_size == SZ_W)
            eff_addr[1:0] = 2'b00;
    end
    assign req_err = (req_size == SZ_RSV);
`endif

    assign word_hi  = eff_addr[ADDR_W-1:2];
    assign off      = eff_addr[1:0];
    assign mem_word = {mem[{word_hi, 2'd3}], mem[{word_hi, 2'd2}],
                       mem[{word_hi, 2'd1}], mem[{word_hi, 2'd0}]};

    // Replicate store data across lanes; the byte enables pick the lanes that land.
    always_comb begin
        be   = 4'b0000;
        lane = req_wdata;
        case (req_size)
            SZ_B: begin
                be   = 4'b0001 << off;
                lane = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be   = 4'b0011 << off;
                lane = {2{req_wdata[15:0]}};
            end
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wr_en = accept && req_we && !req_err;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[{word_hi, 2'(i)}] <= lane[8*i +: 8];
            end
        end
    end

    // Accepting edge feeds the response straight from memory; otherwise from the holding register.
    assign src_word = accept ? mem_word     : hold_word;
    assign src_off  = accept ? off          : hold_off;
    assign src_size = accept ? req_size     : hold_size;
    assign src_uns  = accept ? req_unsigned : hold_uns;
    assign src_we   = accept ? req_we       : hold_we;
    assign src_err  = accept ? req_err      : hold_err;

    dm_ext u_ext (
        .word        (src_word),
        .off         (src_off),
        .size        (src_size),
        .is_unsigned (src_uns),
        .data        (ext_data)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept)
                    next_state = (req_we || RD_LAT == 1) ? S_RESP : S_WAIT;
                else
                    next_state = S_IDLE;
            end
            S_WAIT:  next_state = (cnt == 2'd1) ? S_RESP : S_WAIT;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            hold_word <= '0;
            hold_off  <= 2'b00;
            hold_size <= 2'b00;
            hold_uns  <= 1'b0;
            hold_we   <= 1'b0;
            hold_err  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= next_state;
            if (accept && !req_we && RD_LAT > 1)
                cnt <= LAT_INIT;
            else if (state == S_WAIT)
                cnt <= cnt - 2'd1;
            if (accept) begin
                hold_word <= mem_word;
                hold_off  <= off;
                hold_size <= req_size;
                hold_uns  <= req_unsigned;
                hold_we   <= req_we;
                hold_err  <= req_err;
            end
            valid_q <= (next_state == S_RESP);
            err_q   <= (next_state == S_RESP) && src_err;
            rdata_q <= (next_state == S_RESP && !src_we && !src_err) ? ext_data : '0;
        end
    end

    // rst gates the outputs in the same cycle so an abandoned response never shows.
    assign resp_valid = valid_q && !rst;
    assign resp_err   = err_q && !rst;
    assign resp_rdata = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_dm_param.sv
// Directed self-checking bench for dm_param: three instances (RD_LAT 1, 3, 4)
// share request fields; each has its own req_valid and response outputs.
module tb_dm_param;
    import dm_pkg::*;

    typedef struct {
        logic [1:0]  sz;
        logic        u;
        logic [9:0]  a;
        logic [31:0] exp;
    } ld_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  vld = 3'b000;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  re;
    logic [2:0][31:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_param #(.ADDR_W(10), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(re[0])
    );

    dm_param #(.ADDR_W(10), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(re[1])
    );

    dm_param #(.ADDR_W(10), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(re[2])
    );

    // Issue one request to instance k and wait (bounded) for its response strobe.
    task automatic do_req(input int k, input logic w, input logic [1:0] sz, input logic u,
                          input logic [9:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err, output int lat);
        we = w; size = sz; uns = u; addr = a; wdata = d;
        vld[k] = 1'b1;
        @(posedge clk); #1;
        vld[k] = 1'b0;
        lat = 1;
        while (rv[k] !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rv[k] !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout inst%0d: no resp_valid within %0d cycles", k, lat);
        end
        rdata = rd[k];
        err   = re[k];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b0 || rv[k] !== 1'b0 || rd[k] !== 32'h0 || re[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: got ready=%b valid=%b rdata=%h err=%b, want all 0",
                         k, rdy[k], rv[k], rd[k], re[k]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 111", rdy);
        end
    endtask

    task automatic test_word();
        logic [31:0] r; logic e; int l;
        do_req(0, 1'b1, SZ_W, 1'b0, 10'h010, 32'hDEADBEEF, r, e, l);
        checks++;
        if (r !== 32'h0 || e !== 1'b0 || l != 1) begin
            errors++;
            $display("FAIL store_ack: got rdata=%h err=%b lat=%0d, want 00000000 0 1", r, e, l);
        end
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hDEADBEEF || e !== 1'b0 || l != 1) begin
            errors++;
            $display("FAIL word_load: got rdata=%h err=%b lat=%0d, want deadbeef 0 1", r, e, l);
        end
    endtask

    task automatic test_ext();
        ld_vec_t vec [8];
        logic [31:0] r; logic e; int l;
        vec = '{'{2'b00, 1'b0, 10'h010, 32'hFFFFFFEF},
                '{2'b00, 1'b1, 10'h010, 32'h000000EF},
                '{2'b01, 1'b0, 10'h012, 32'hFFFFDEAD},
                '{2'b01, 1'b1, 10'h012, 32'h0000DEAD},
                '{2'b00, 1'b0, 10'h013, 32'hFFFFFFDE},
                '{2'b00, 1'b1, 10'h011, 32'h000000BE},
                '{2'b01, 1'b0, 10'h010, 32'hFFFFBEEF},
                '{2'b01, 1'b1, 10'h010, 32'h0000BEEF}};
        for (int i = 0; i < 8; i++) begin
            do_req(0, 1'b0, vec[i].sz, vec[i].u, vec[i].a, 32'h0, r, e, l);
            checks++;
            if (r !== vec[i].exp || e !== 1'b0 || l != 1) begin
                errors++;
                $display("FAIL ext_load[%0d]: got rdata=%h err=%b lat=%0d, want %h 0 1",
                         i, r, e, l, vec[i].exp);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] r; logic e; int l;
        do_req(0, 1'b1, SZ_B, 1'b0, 10'h011, 32'hAABBCC55, r, e, l);
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hDEAD55EF || e !== 1'b0) begin
            errors++;
            $display("FAIL byte_store: got rdata=%h err=%b, want dead55ef 0", r, e);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] r; logic e; int l;
        do_req(0, 1'b1, SZ_H, 1'b0, 10'h016, 32'h1234BEEF, r, e, l);
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h014, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hBEEF0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL half_store: got rdata=%h err=%b, want beef0000 0", r, e);
        end
    endtask

    task automatic test_align();
        logic [31:0] r; logic e; int l;
        logic        exp_err;
        logic [31:0] exp_w10;
`ifdef DM_ALIGN_CHECK_EN
        exp_err = 1'b1;
        exp_w10 = 32'hDEAD55EF;
`else
        exp_err = 1'b0;
        exp_w10 = 32'h11223344;
`endif
        do_req(0, 1'b1, SZ_W, 1'b0, 10'h013, 32'h11223344, r, e, l);
        checks++;
        if (e !== exp_err || r !== 32'h0 || l != 1) begin
            errors++;
            $display("FAIL misaligned_store: got err=%b rdata=%h lat=%0d, want %b 00000000 1", e, r, l, exp_err);
        end
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, r, e, l);
        checks++;
        if (r !== exp_w10) begin
            errors++;
            $display("FAIL misaligned_mem10: got %h want %h", r, exp_w10);
        end
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h014, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hBEEF0000) begin
            errors++;
            $display("FAIL misaligned_mem14: got %h want beef0000", r);
        end
        do_req(0, 1'b1, SZ_RSV, 1'b0, 10'h010, 32'hFFFFFFFF, r, e, l);
        checks++;
        if (e !== 1'b1 || r !== 32'h0 || l != 1) begin
            errors++;
            $display("FAIL reserved_store: got err=%b rdata=%h lat=%0d, want 1 00000000 1", e, r, l);
        end
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, r, e, l);
        checks++;
        if (r !== exp_w10) begin
            errors++;
            $display("FAIL reserved_no_write: got %h want %h", r, exp_w10);
        end
        do_req(1, 1'b0, SZ_RSV, 1'b0, 10'h020, 32'h0, r, e, l);
        checks++;
        if (e !== 1'b1 || r !== 32'h0 || l != 3) begin
            errors++;
            $display("FAIL reserved_load: got err=%b rdata=%h lat=%0d, want 1 00000000 3", e, r, l);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r; logic e; int l;
        do_req(0, 1'b1, SZ_B, 1'b0, 10'h3FF, 32'h000000A5, r, e, l);
        do_req(0, 1'b0, SZ_B, 1'b1, 10'h3FF, 32'h0, r, e, l);
        checks++;
        if (r !== 32'h000000A5) begin
            errors++;
            $display("FAIL top_byte_unsigned: got %h want 000000a5", r);
        end
        do_req(0, 1'b0, SZ_B, 1'b0, 10'h3FF, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hFFFFFFA5) begin
            errors++;
            $display("FAIL top_byte_signed: got %h want ffffffa5", r);
        end
        do_req(0, 1'b0, SZ_W, 1'b0, 10'h3FC, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hA5000000) begin
            errors++;
            $display("FAIL top_word: got %h want a5000000", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic e; int l;
        logic [9:0]  la [3];
        logic [31:0] le [3];
        int          issued, got, low;
        logic        acc;
        la = '{10'h020, 10'h024, 10'h020};
        le = '{32'h01020304, 32'h0A0B0C0D, 32'h01020304};
        do_req(1, 1'b1, SZ_W, 1'b0, 10'h020, 32'h01020304, r, e, l);
        checks++;
        if (l != 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL lat3_store_ack: got lat=%0d err=%b, want 1 0", l, e);
        end
        do_req(1, 1'b1, SZ_W, 1'b0, 10'h024, 32'h0A0B0C0D, r, e, l);
        issued = 0; got = 0; low = 0;
        we = 1'b0; size = SZ_W; uns = 1'b0; addr = la[0];
        vld[1] = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            acc = vld[1] && rdy[1];
            if (!rdy[1]) low++;
            if (rv[1]) begin
                checks++;
                if (got >= 3) begin
                    errors++;
                    $display("FAIL b2b_extra_resp: response at cycle %0d after 3 already seen", cyc);
                end else if (cyc != 3 * (got + 1) || rd[1] !== le[got]) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: got cycle=%0d rdata=%h, want cycle=%0d rdata=%h",
                             got, cyc, rd[1], 3 * (got + 1), le[got]);
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                issued++;
                if (issued < 3) addr = la[issued];
                else vld[1] = 1'b0;
            end
        end
        vld[1] = 1'b0;
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL b2b_resp_count: got %0d want 3", got);
        end
        checks++;
        if (low != 6) begin
            errors++;
            $display("FAIL b2b_ready_low: got %0d cycles want 6", low);
        end
    endtask

    task automatic test_rst_wait();
        logic [31:0] r; logic e; int l;
        int          seen;
        do_req(2, 1'b1, SZ_W, 1'b0, 10'h030, 32'hCAFEF00D, r, e, l);
        we = 1'b0; size = SZ_W; uns = 1'b0; addr = 10'h030;
        vld[2] = 1'b1;
        @(posedge clk); #1;
        vld[2] = 1'b0;
        checks++;
        if (rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready: got %b want 0", rdy[2]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy[2] !== 1'b0 || rv[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_wait: got ready=%b valid=%b, want 0 0", rdy[2], rv[2]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_wait_rst: got %b want 111", rdy);
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv[2]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abandoned_resp: got %0d strobes want 0", seen);
        end
        do_req(2, 1'b0, SZ_W, 1'b0, 10'h030, 32'h0, r, e, l);
        checks++;
        if (r !== 32'hCAFEF00D || e !== 1'b0 || l != 4) begin
            errors++;
            $display("FAIL load_after_rst: got rdata=%h err=%b lat=%0d, want cafef00d 0 4", r, e, l);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_ext();
        test_byte_store();
        test_half_store();
        test_align();
        test_wrap();
        test_back_to_back();
        test_rst_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
